regfile_wb_sched: RTL

Writeback scheduler and scoreboard for the 32x32 register file, which has two combinational read ports and one clocked write port.
- Arbitrates the ALU and LSU writeback streams onto the single write port.
- Tracks which destination registers have writes in flight.
- Stalls decode on RAW/WAW hazards.
- Sits between decode, execute/LSU writeback and the register file write port.

---
 rtl/regfile_pkg.sv | 24 ++
 rtl/regfile_wb_sched_arb.sv | 40 ++++
 rtl/regfile_wb_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback scheduler.
//   XLEN   : register data width
//   NREG   : number of architectural registers
//   REG_AW : register index width
//   wb_src_e : writeback source identifier (ALU / LSU)
//   wb_req_t : one writeback request {valid, rd, data}
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_sched_arb.sv
// wb_rr_arb2: two-requester round-robin arbiter for the writeback port.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_req_alu    : ALU writeback request
//   i_req_lsu    : LSU writeback request
//   o_gnt_alu    : ALU granted this cycle (combinational)
//   o_gnt_lsu    : LSU granted this cycle (combinational)
// rr_last remembers the winner of the most recent tie; it only moves when
// both sources contend, so a lone requester does not disturb the rotation.
module wb_rr_arb2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_alu,
  input  logic i_req_lsu,
  output logic o_gnt_alu,
  output logic o_gnt_lsu
);

  wb_src_e r_rr_last;
  logic    w_tie;

  assign w_tie = i_req_alu && i_req_lsu;

  always_comb begin
    o_gnt_alu = i_req_alu && (!i_req_lsu || (r_rr_last == WB_LSU));
    o_gnt_lsu = i_req_lsu && (!i_req_alu || (r_rr_last == WB_ALU));
  end

  // Reset to LSU so the ALU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_last <= WB_LSU;
    end else if (w_tie) begin
      r_rr_last <= o_gnt_alu ? WB_ALU : WB_LSU;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: writeback scheduler and scoreboard for a 32x32 register
// file with one clocked write port.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   issue_valid/rs1/rs2/rd/rd_we       : instruction presented by decode
//   issue_ready                        : no RAW/WAW hazard against pending writes
//   alu_wb_valid/rd/data, alu_wb_ready : ALU writeback stream + grant
//   lsu_wb_valid/rd/data, lsu_wb_ready : LSU writeback stream + grant
//   rf_r_write/rf_data_write/rf_enable_write : register file write port
//   busy_mask                          : pending-write bitmap
// Optional build macro REGFILE_WB_BYPASS_EN: the register being written this
// cycle counts as already free for hazard checks, and fwd_rs1_hit /
// fwd_rs2_hit / fwd_data let decode forward the value over the stale read.
module regfile_wb_sched
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_rd_we,
  output logic              issue_ready,
  input  logic              alu_wb_valid,
  input  logic [REG_AW-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]   alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              lsu_wb_valid,
  input  logic [REG_AW-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]   lsu_wb_data,
  output logic              lsu_wb_ready,
  output logic [REG_AW-1:0] rf_r_write,
  output logic [XLEN-1:0]   rf_data_write,
  output logic              rf_enable_write,
`ifdef REGFILE_WB_BYPASS_EN
  output logic              fwd_rs1_hit,
  output logic              fwd_rs2_hit,
  output logic [XLEN-1:0]   fwd_data,
`endif
  output logic [NREG-1:0]   busy_mask
);

  wb_req_t           w_alu_req;
  wb_req_t           w_lsu_req;
  wb_req_t           w_win;
  logic              w_gnt_alu;
  logic              w_gnt_lsu;

  logic [NREG-1:0]   r_pending;
  logic [NREG-1:0]   w_pending_nxt;
  logic [NREG-1:0]   w_set_mask;
  logic [NREG-1:0]   w_clr_mask;
  logic [NREG-1:0]   w_pend_chk;
  logic              w_issue_fire;

  logic [REG_AW-1:0] r_rf_idx;
  logic [XLEN-1:0]   r_rf_data;
  logic              r_rf_we;

  assign w_alu_req = '{valid: alu_wb_valid, rd: alu_wb_rd, data: alu_wb_data};
  assign w_lsu_req = '{valid: lsu_wb_valid, rd: lsu_wb_rd, data: lsu_wb_data};

  wb_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req_alu (w_alu_req.valid),
    .i_req_lsu (w_lsu_req.valid),
    .o_gnt_alu (w_gnt_alu),
    .o_gnt_lsu (w_gnt_lsu)
  );

  assign alu_wb_ready = w_gnt_alu;
  assign lsu_wb_ready = w_gnt_lsu;

  // Winning request; valid marks that some source was granted this cycle.
  always_comb begin
    w_win       = w_gnt_alu ? w_alu_req : w_lsu_req;
    w_win.valid = w_gnt_alu || w_gnt_lsu;
  end

  // Write stage: index/data hold when idle, only the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we   <= 1'b0;
      r_rf_idx  <= '0;
      r_rf_data <= '0;
    end else if (w_win.valid) begin
      r_rf_we   <= (w_win.rd != '0);
      r_rf_idx  <= w_win.rd;
      r_rf_data <= w_win.data;
    end else begin
      r_rf_we   <= 1'b0;
    end
  end

  assign rf_r_write      = r_rf_idx;
  assign rf_data_write   = r_rf_data;
  assign rf_enable_write = r_rf_we;

  // Scoreboard: a commit clears its bit on the same edge the regfile writes.
  assign w_clr_mask = r_rf_we ? (NREG'(1) << r_rf_idx) : '0;

`ifdef REGFILE_WB_BYPASS_EN
  assign w_pend_chk = r_pending & ~w_clr_mask;
`else
  assign w_pend_chk = r_pending;
`endif

  assign issue_ready  = !w_pend_chk[issue_rs1] && !w_pend_chk[issue_rs2] &&
                        !(issue_rd_we && w_pend_chk[issue_rd]);
  assign w_issue_fire = issue_valid && issue_ready;
  assign w_set_mask   = (w_issue_fire && issue_rd_we && (issue_rd != '0)) ?
                        (NREG'(1) << issue_rd) : '0;

  // Set is applied after clear so a same-edge set/clear leaves the bit set;
  // x0 is never tracked.
  always_comb begin
    w_pending_nxt    = (r_pending & ~w_clr_mask) | w_set_mask;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign busy_mask = r_pending;

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd_rs1_hit = r_rf_we && (issue_rs1 == r_rf_idx) && (issue_rs1 != '0);
  assign fwd_rs2_hit = r_rf_we && (issue_rs2 == r_rf_idx) && (issue_rs2 != '0);
  assign fwd_data    = r_rf_data;
`endif

endmodule
